sccb_cfg_sequencer: RTL
=======================

Name: sccb_cfg_sequencer

Overview:
- Sequences the OV7670 register-configuration ROM into the SCCB byte-write engine.
- Walks the ROM and decodes its marker entries: FFF0 is a delay, FFFF is end-of-table.
- Enforces the inter-write gap and shares the engine with a host port that issues single runtime register writes (focus/exposure tweaks).
- Sits between the config ROM, the SCCB master and the top-level control logic.

Parameters:
- ADDR_W, 8: ROM address width.
- LAST_ADDR, 255: highest ROM address walked; end of table if no FFFF is seen first.
- GAP_CYCLES, 25000: idle clk cycles after each completed write (250 us at 100 MHz).
- DELAY_CYCLES, 1000000: wait for an FFF0 entry (10 ms at 100 MHz).
- RETRY_MAX, 3: retries per entry; only used with SCCB_RETRY_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins the configuration walk.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_data  in  16  ROM word; [15:8] register address, [7:0] data; 1-cycle synchronous read latency.
- wr_req  out  1  write request to the SCCB engine.
- wr_reg  out  8  register address for the engine.
- wr_data  out  8  data byte for the engine.
- wr_ack  in  1  engine accepted the request (1-cycle pulse).
- wr_done  in  1  transaction finished (1-cycle pulse).
- wr_nack  in  1  slave NACK; valid only in the cycle wr_done is high.
- host_req  in  1  host write request, level.
- host_reg  in  8  host register address.
- host_data  in  8  host data byte.
- host_grant  out  1  1-cycle pulse when the host request is latched.
- host_done  out  1  1-cycle pulse when the host write completes.
- busy  out  1  high whenever not IDLE/DONE.
- cfg_done  out  1  high from end of walk until the next start.
- err  out  1  sticky NACK flag; cleared on start.

Behaviour:
- Reset values: all outputs 0, rom_addr 0, state IDLE. An in-flight transaction is abandoned and wr_req drops immediately.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, HOST_ISSUE, HOST_WAIT, DONE.
- IDLE/DONE:
  - start has priority: clear err and cfg_done, rom_addr <= 0, go to FETCH.
  - Else if host_req: latch host_reg/host_data, pulse host_grant, go to HOST_ISSUE.
- FETCH: one wait cycle covers the ROM latency; rom_data is sampled in DECODE, 2 cycles after the rom_addr update.
- DECODE:
  - FFFF -> DONE, and cfg_done goes high.
  - FFF0 -> DELAY.
  - Any other word -> latch wr_reg/wr_data, go to ISSUE.
- ISSUE/HOST_ISSUE:
  - wr_req is high; wr_reg/wr_data are stable.
  - On the cycle wr_ack is sampled high, wr_req drops on the next edge and the state moves to WAIT_DONE/HOST_WAIT.
  - wr_req is never high for more than one request.
- WAIT_DONE: on wr_done, go to GAP. If wr_nack, set err.
- HOST_WAIT: on wr_done, pulse host_done and go to GAP. Afterwards return to DONE if cfg_done=1, else IDLE.
- GAP: count GAP_CYCLES, then:
  - In a walk with rom_addr==LAST_ADDR: go to DONE.
  - Otherwise in a walk: rom_addr++, go to FETCH.
- DELAY: count DELAY_CYCLES, then advance exactly as at the end of GAP.
- Counters: one shared 20-bit down-counter, loaded on entry to GAP/DELAY. Expiry occurs when it reads 0.
- Simultaneous events:
  - start during a walk or host transaction: ignored, no latching.
  - host_req during a walk: held pending by the requester (level) and served after DONE.
  - wr_ack and wr_done in the same cycle: treated as ack followed by done; go straight to GAP.
- wr_done with no outstanding request: ignored.

Optional Feature:
- Macro: SCCB_RETRY_EN.
- Defined:
  - A NACK in WAIT_DONE/HOST_WAIT re-enters ISSUE/HOST_ISSUE with the same reg/data after GAP_CYCLES.
  - Up to RETRY_MAX retries per entry. If the final attempt still NACKs, set err and continue (host_done still pulses).
  - Retry counter is 2 bits and resets per entry.
- Undefined: a NACK only sets err; no re-issue.

Test Plan:
- ROM {0:1280, 1:1214, 2:FFFF}, engine acks in 3 cycles, done in 20 cycles, start pulse:
  - Exactly two writes, (12,80) then (12,14).
  - Writes spaced by 25000 cycles of GAP.
  - cfg_done rises with busy falling, with no third wr_req.
- ROM {0:1280, 1:FFF0, 2:1211, 3:FFFF}: the write of 1211 starts no earlier than 25000+1000000 cycles after the first wr_done.
- ROM all non-FFFF with LAST_ADDR=3: exactly 4 writes (addresses 0..3), then DONE.
- host_req=1 with reg 0x55, data 0xAA, asserted mid-walk: no grant until cfg_done. Then host_grant, a single write (55,AA), host_done; state returns to DONE.
- wr_nack on the first write:
  - Without macro: err=1 and the walk continues.
  - With SCCB_RETRY_EN and NACK on every attempt: 4 wr_req for the entry, then err=1 and the next entry is issued.
- reset_n low during WAIT_DONE: wr_req, busy, cfg_done and err are all 0 asynchronously. A fresh start restarts from rom_addr 0.

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_sequencer
// Brief    : Walks the OV7670 configuration ROM and feeds register writes to
//            the SCCB byte-write engine. Decodes FFF0 (delay) and FFFF
//            (end-of-table) markers, enforces an idle gap after every write,
//            and serves single host register writes when no walk is running.
//            Optional macro SCCB_RETRY_EN re-issues NACKed writes up to
//            RETRY_MAX times before flagging err.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_cfg_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int LAST_ADDR    = 255,
    parameter int GAP_CYCLES   = 25000,
    parameter int DELAY_CYCLES = 1000000,
    parameter int RETRY_MAX    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              wr_req,
    output logic [7:0]        wr_reg,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    input  logic              wr_done,
    input  logic              wr_nack,
    input  logic              host_req,
    input  logic [7:0]        host_reg,
    input  logic [7:0]        host_data,
    output logic              host_grant,
    output logic              host_done,
    output logic              busy,
    output logic              cfg_done,
    output logic              err
);

    // State encoding
    localparam logic [3:0] c_st_idle       = 4'd0;
    localparam logic [3:0] c_st_fetch      = 4'd1;
    localparam logic [3:0] c_st_decode     = 4'd2;
    localparam logic [3:0] c_st_issue      = 4'd3;
    localparam logic [3:0] c_st_wait_done  = 4'd4;
    localparam logic [3:0] c_st_gap        = 4'd5;
    localparam logic [3:0] c_st_delay      = 4'd6;
    localparam logic [3:0] c_st_host_issue = 4'd7;
    localparam logic [3:0] c_st_host_wait  = 4'd8;
    localparam logic [3:0] c_st_done       = 4'd9;

    // The shared down-counter is loaded with N-1 so that the state is held
    // for exactly N cycles before expiry at zero.
    localparam logic [19:0]       c_gap_load   = 20'(GAP_CYCLES - 1);
    localparam logic [19:0]       c_delay_load = 20'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(LAST_ADDR);
    localparam logic [1:0]        c_retry_max  = 2'(RETRY_MAX);

`ifdef SCCB_RETRY_EN
    localparam logic c_retry_en = 1'b1;
`else
    localparam logic c_retry_en = 1'b0;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [19:0]       r_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_walk;
    logic [7:0]        r_wr_reg;
    logic [7:0]        r_wr_data;
    logic              r_host_grant;
    logic              r_host_done;
    logic              r_cfg_done;
    logic              r_err;
    logic [1:0]        r_retry_cnt;
    logic              r_retry_pend;

    logic w_idle;
    logic w_start_acc;
    logic w_host_acc;
    logic w_issue;
    logic w_wait;
    logic w_host_phase;
    logic w_done_evt;
    logic w_retry;
    logic w_timed;
    logic w_cnt_zero;
    logic w_last;
    logic w_rom_end;
    logic w_rom_delay;

    assign w_idle       = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_start_acc  = w_idle && start;
    assign w_host_acc   = w_idle && !start && host_req;
    assign w_issue      = (r_state == c_st_issue) || (r_state == c_st_host_issue);
    assign w_wait       = (r_state == c_st_wait_done) || (r_state == c_st_host_wait);
    assign w_host_phase = (r_state == c_st_host_issue) || (r_state == c_st_host_wait);
    // A done pulse only counts when a request is outstanding: either waiting
    // for it, or arriving together with the ack.
    assign w_done_evt   = (w_issue && wr_ack && wr_done) || (w_wait && wr_done);
    assign w_retry      = c_retry_en && wr_nack && (r_retry_cnt < c_retry_max);
    assign w_timed      = (r_state == c_st_gap) || (r_state == c_st_delay);
    assign w_cnt_zero   = (r_cnt == 20'd0);
    assign w_last       = (r_rom_addr == c_last_addr);
    assign w_rom_end    = (rom_data == 16'hFFFF);
    assign w_rom_delay  = (rom_data == 16'hFFF0);

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_next = c_st_fetch;
                end else if (host_req) begin
                    w_next = c_st_host_issue;
                end
            end
            c_st_fetch: begin
                w_next = c_st_decode;
            end
            c_st_decode: begin
                if (w_rom_end) begin
                    w_next = c_st_done;
                end else if (w_rom_delay) begin
                    w_next = c_st_delay;
                end else begin
                    w_next = c_st_issue;
                end
            end
            c_st_issue: begin
                if (wr_ack) begin
                    w_next = wr_done ? c_st_gap : c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (wr_done) begin
                    w_next = c_st_gap;
                end
            end
            c_st_host_issue: begin
                if (wr_ack) begin
                    w_next = wr_done ? c_st_gap : c_st_host_wait;
                end
            end
            c_st_host_wait: begin
                if (wr_done) begin
                    w_next = c_st_gap;
                end
            end
            c_st_gap: begin
                if (w_cnt_zero) begin
                    if (r_retry_pend) begin
                        w_next = r_walk ? c_st_issue : c_st_host_issue;
                    end else if (r_walk) begin
                        w_next = w_last ? c_st_done : c_st_fetch;
                    end else begin
                        w_next = r_cfg_done ? c_st_done : c_st_idle;
                    end
                end
            end
            c_st_delay: begin
                if (w_cnt_zero) begin
                    w_next = w_last ? c_st_done : c_st_fetch;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // Shared gap/delay down-counter, loaded on entry to GAP or DELAY
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 20'd0;
        end else if ((w_next == c_st_gap) && (r_state != c_st_gap)) begin
            r_cnt <= c_gap_load;
        end else if ((w_next == c_st_delay) && (r_state != c_st_delay)) begin
            r_cnt <= c_delay_load;
        end else if (w_timed && !w_cnt_zero) begin
            r_cnt <= r_cnt - 20'd1;
        end
    end

    // ROM address walk and walk/host ownership flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_walk     <= 1'b0;
        end else if (w_start_acc) begin
            r_rom_addr <= '0;
            r_walk     <= 1'b1;
        end else if (w_host_acc) begin
            r_walk     <= 1'b0;
        end else if (w_timed && (w_next == c_st_fetch)) begin
            r_rom_addr <= r_rom_addr + 1'b1;
        end
    end

    // Register/data latch for the engine; held stable while wr_req is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_reg  <= 8'd0;
            r_wr_data <= 8'd0;
        end else if ((r_state == c_st_decode) && !w_rom_end && !w_rom_delay) begin
            r_wr_reg  <= rom_data[15:8];
            r_wr_data <= rom_data[7:0];
        end else if (w_host_acc) begin
            r_wr_reg  <= host_reg;
            r_wr_data <= host_data;
        end
    end

    // Status flags and host handshake pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_host_grant <= 1'b0;
            r_host_done  <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_host_grant <= w_host_acc;
            r_host_done  <= w_done_evt && w_host_phase && !w_retry;
            if (w_start_acc) begin
                r_cfg_done <= 1'b0;
            end else if (w_next == c_st_done) begin
                r_cfg_done <= 1'b1;
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_done_evt && wr_nack && !w_retry) begin
                r_err <= 1'b1;
            end
        end
    end

    // Per-entry retry bookkeeping; constant zero when retries are disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retry_cnt  <= 2'd0;
            r_retry_pend <= 1'b0;
        end else if (w_start_acc || w_host_acc || (r_state == c_st_decode)) begin
            r_retry_cnt  <= 2'd0;
            r_retry_pend <= 1'b0;
        end else if (w_done_evt) begin
            r_retry_pend <= w_retry;
            if (w_retry) begin
                r_retry_cnt <= r_retry_cnt + 2'd1;
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign wr_req     = w_issue;
    assign wr_reg     = r_wr_reg;
    assign wr_data    = r_wr_data;
    assign host_grant = r_host_grant;
    assign host_done  = r_host_done;
    assign busy       = !w_idle;
    assign cfg_done   = r_cfg_done;
    assign err        = r_err;

endmodule
`default_nettype wire
